// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: state encoding and frame bit positions shared by the PS/2 receiver files.
package ps2_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  localparam int FRAME_BITS = 11;
  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: first-word-fall-through byte FIFO; head byte is visible on dout while not empty.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign push_ok = push && (!full || pop_ok);
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_rx_frame_fifo.sv
// ps2_rx_frame_fifo: PS/2 receiver with clock glitch filter, frame checks and a byte FIFO.
// PS2_RX_TIMEOUT_EN adds a mid-frame inactivity abort after TIMEOUT_CYCLES.
module ps2_rx_frame_fifo
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2data,
  input  logic                        ps2clk,
  input  logic                        rx_en,
  input  logic                        rd_en,
  output logic [7:0]                  dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        rx_done_tick,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun
);
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d, fall_edge;
  logic [1:0]            sync_q, sync_d;
  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  chk, frame_ok, parity_ok, push, to_d, to_q;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  assign chk          = state_q == CHECK;
  assign frame_ok     = !frame_q[START_BIT] && frame_q[STOP_BIT];
  assign parity_ok    = ^frame_q[PARITY_BIT:DATA_LSB];
  assign push         = chk && frame_ok && parity_ok;
  assign rx_done_tick = chk || to_q;
  assign frame_err    = (chk && !frame_ok) || to_q;
  assign parity_err   = chk && frame_ok && !parity_ok;
  assign overrun      = push && full && !rd_en;
  always_comb begin
    filt_d    = {ps2clk, filt_q[FILTER_LEN-1:1]};
    fclk_d    = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fclk_q;
    fall_edge = fclk_q & ~fclk_d;
    sync_d    = {sync_q[0], ps2data};
    state_d   = state_q;
    n_d       = n_q;
    frame_d   = frame_q;
    to_d      = 1'b0;
    if (fall_edge && ((state_q == IDLE && rx_en) || state_q == DATA))
      frame_d = {sync_q[1], frame_q[FRAME_BITS-1:1]};
    if (state_q == IDLE && fall_edge && rx_en) begin
      state_d = DATA;
      n_d     = 4'd9;
    end else if (state_q == DATA && fall_edge) begin
      state_d = n_q == 4'd0 ? CHECK : DATA;
      n_d     = n_q - 4'd1;
    end else if (state_q == CHECK) begin
      state_d = IDLE;
    end
`ifdef PS2_RX_TIMEOUT_EN
    tmo_d = (state_q == DATA && !fall_edge) ? tmo_q + 1'b1 : '0;
    to_d  = state_q == DATA && !fall_edge && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    if (to_d) state_d = IDLE;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q  <= '0;
      fclk_q  <= 1'b0;
      sync_q  <= '0;
      state_q <= IDLE;
      n_q     <= '0;
      frame_q <= '0;
      to_q    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      filt_q  <= filt_d;
      fclk_q  <= fclk_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      n_q     <= n_d;
      frame_q <= frame_d;
      to_q    <= to_d;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
  ps2_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd_en),
    .din   (frame_q[DATA_MSB:DATA_LSB]),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );
endmodule

// File: tb/tb_ps2_rx_frame_fifo.sv
// tb_ps2_rx_frame_fifo: directed frames with hand-computed bytes, flags and pulse counts.
module tb_ps2_rx_frame_fifo;
  logic       clk = 1'b0;
  logic       reset, ps2data, ps2clk, rx_en, rd_en;
  logic [7:0] dout;
  logic       empty, full, rx_done_tick, parity_err, frame_err, overrun;
  logic [2:0] count;
  int pass_n = 0, total_n = 0;
  int done_n = 0, perr_n = 0, ferr_n = 0, ovr_n = 0;
  int d0, p0, f0, o0;

  ps2_rx_frame_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .ps2data(ps2data), .ps2clk(ps2clk), .rx_en(rx_en),
    .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
    .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) done_n++;
    if (parity_err) perr_n++;
    if (frame_err) ferr_n++;
    if (overrun) ovr_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frm(input logic [7:0] d, input logic bad_par, input logic stop);
    return {stop, ~^d ^ bad_par, d, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input int nbits, input bit drop_en, input bit rd_chk);
    for (int i = 0; i < nbits; i++) begin
      ps2data = f[i];
      cyc(20);
      ps2clk = 1'b0;
      if (rd_chk && i == 10) begin
        cyc(9);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(10);
      end else cyc(20);
      ps2clk = 1'b1;
      if (drop_en && i == 0) rx_en = 1'b0;
    end
    cyc(20);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic snap;
    d0 = done_n; p0 = perr_n; f0 = ferr_n; o0 = ovr_n;
  endtask

  initial begin
    reset = 1'b1; ps2data = 1'b1; ps2clk = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
    cyc(3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 8'h00);
    reset = 1'b0;
    cyc(20);
    check("idle_pulses", done_n + perr_n + ferr_n + ovr_n, 0);

    snap();
    send(frm(8'h1C, 0, 1), 11, 0, 0);
    check("v_done", done_n - d0, 1);
    check("v_empty", empty, 0);
    check("v_dout", dout, 8'h1C);
    check("v_count", count, 1);
    check("v_errs", (perr_n - p0) + (ferr_n - f0) + (ovr_n - o0), 0);
    pop();
    check("v_pop_empty", empty, 1);

    snap();
    send(frm(8'h1C, 1, 1), 11, 0, 0);
    check("par_err", perr_n - p0, 1);
    check("par_ferr", ferr_n - f0, 0);
    check("par_empty", empty, 1);

    snap();
    send(frm(8'hF0, 0, 0), 11, 0, 0);
    check("frm_err", ferr_n - f0, 1);
    check("frm_perr", perr_n - p0, 0);
    check("frm_done", done_n - d0, 1);
    check("frm_empty", empty, 1);

    snap();
    for (int b = 1; b <= 4; b++) send(frm(8'(b), 0, 1), 11, 0, 0);
    check("ovr_full4", full, 1);
    check("ovr_count4", count, 4);
    check("ovr_none4", ovr_n - o0, 0);
    send(frm(8'h05, 0, 1), 11, 0, 0);
    check("ovr_pulse", ovr_n - o0, 1);
    check("ovr_count5", count, 4);
    for (int b = 1; b <= 4; b++) begin
      check("ovr_order", dout, 32'(b));
      pop();
    end
    check("ovr_drained", empty, 1);

    snap();
    for (int b = 1; b <= 4; b++) send(frm(8'(b), 0, 1), 11, 0, 0);
    send(frm(8'h05, 0, 1), 11, 0, 1);
    check("rdw_no_ovr", ovr_n - o0, 0);
    check("rdw_full", full, 1);
    for (int b = 2; b <= 5; b++) begin
      check("rdw_order", dout, 32'(b));
      pop();
    end
    check("rdw_drained", empty, 1);

    snap();
    ps2data = 1'b0;
    ps2clk = 1'b0;
    cyc(7);
    ps2clk = 1'b1;
    cyc(30);
    check("glitch_done", done_n - d0, 0);
    send(frm(8'h1C, 0, 1), 11, 0, 0);
    check("glitch_after", dout, 8'h1C);
    check("glitch_count", count, 1);
    pop();

    snap();
    rx_en = 1'b0;
    send(frm(8'h1C, 0, 1), 11, 0, 0);
    check("rxen_off_done", done_n - d0, 0);
    check("rxen_off_empty", empty, 1);
    rx_en = 1'b1;

    snap();
    send(frm(8'hA5, 0, 1), 11, 1, 0);
    check("rxen_drop_done", done_n - d0, 1);
    check("rxen_drop_dout", dout, 8'hA5);
    pop();
    rx_en = 1'b1;

`ifdef PS2_RX_TIMEOUT_EN
    snap();
    send(frm(8'h1C, 0, 1), 5, 0, 0);
    for (int k = 0; k < 200 && ferr_n == f0; k++) cyc(1);
    check("to_ferr", ferr_n - f0, 1);
    check("to_done", done_n - d0, 1);
    check("to_empty", empty, 1);
    send(frm(8'h1C, 0, 1), 11, 0, 0);
    check("to_next_dout", dout, 8'h1C);
    check("to_next_count", count, 1);
    pop();
`endif

    send(frm(8'h33, 0, 1), 11, 0, 0);
    send(frm(8'h1C, 0, 1), 5, 0, 0);
    reset = 1'b1;
    cyc(2);
    check("mrst_empty", empty, 1);
    check("mrst_full", full, 0);
    check("mrst_count", count, 0);
    check("mrst_dout", dout, 8'h00);
    reset = 1'b0;
    cyc(20);
    snap();
    send(frm(8'h5A, 0, 1), 11, 0, 0);
    check("mrst_next_done", done_n - d0, 1);
    check("mrst_next_dout", dout, 8'h5A);
    check("mrst_next_count", count, 1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
